// File: rtl/poci_readout.sv
// POCI readout: captures the address byte, then streams SYNC_PATTERN and register bytes MSB-first.
// Define POCI_ECHO_ADDR_EN to echo the captured address as the turnaround byte.
module poci_readout #(
  parameter int                BYTE_W       = 8,
  parameter logic [BYTE_W-1:0] SYNC_PATTERN = 8'hA5,
  parameter int                ADDR_W       = 8
) (
  input  logic              sclk,
  input  logic              rstn,
  input  logic              serial_in,
  input  logic [BYTE_W-1:0] reg_rdata,
  output logic              serial_out,
  output logic [ADDR_W-1:0] reg_raddr,
  output logic              rd_strobe,
  output logic              byte_done,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_ADDR = 2'd0,
    ST_TURN = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic [ADDR_W-1:0] addr_sr_q, addr_sr_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              rd_strobe_q, rd_strobe_d;
  logic              byte_done_q, byte_done_d;
  logic              boundary;

  assign boundary = (bit_cnt_q == 3'd7);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q + 3'd1;
    shreg_d     = shreg_q;
    addr_sr_d   = addr_sr_q;
    raddr_d     = raddr_q;
    rd_strobe_d = 1'b0;
    byte_done_d = 1'b0;
    case (state_q)
      ST_ADDR: begin
        addr_sr_d = {addr_sr_q[ADDR_W-2:0], serial_in};
        if (boundary) begin
          raddr_d     = addr_sr_d;
`ifdef POCI_ECHO_ADDR_EN
          shreg_d     = BYTE_W'(addr_sr_d);
`else
          shreg_d     = SYNC_PATTERN;
`endif
          rd_strobe_d = 1'b1;
          byte_done_d = 1'b1;
          state_d     = ST_TURN;
        end
      end
      ST_TURN, ST_DATA: begin
        // reg_rdata has had the whole previous byte to settle at raddr_q.
        if (boundary) begin
          shreg_d     = reg_rdata;
          raddr_d     = raddr_q + ADDR_W'(1);
          rd_strobe_d = 1'b1;
          byte_done_d = 1'b1;
          state_d     = ST_DATA;
        end else begin
          shreg_d = {shreg_q[BYTE_W-2:0], 1'b0};
        end
      end
      default: state_d = ST_ADDR;
    endcase
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_ADDR;
      bit_cnt_q   <= 3'd0;
      shreg_q     <= '0;
      addr_sr_q   <= '0;
      raddr_q     <= '0;
      rd_strobe_q <= 1'b0;
      byte_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      addr_sr_q   <= addr_sr_d;
      raddr_q     <= raddr_d;
      rd_strobe_q <= rd_strobe_d;
      byte_done_q <= byte_done_d;
    end
  end

  assign serial_out = shreg_q[BYTE_W-1];
  assign reg_raddr  = raddr_q;
  assign rd_strobe  = rd_strobe_q;
  assign byte_done  = byte_done_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_poci_readout.sv
// Directed bench for poci_readout; register mux modelled as regs[i] = 3*i (mod 256).
module tb_poci_readout;

  logic       sclk = 1'b0;
  logic       rstn;
  logic       serial_in;
  logic [7:0] reg_rdata;
  logic       serial_out;
  logic [7:0] reg_raddr;
  logic       rd_strobe;
  logic       byte_done;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;
  int done_pulses;
  int strobe_pulses;

`ifdef POCI_ECHO_ADDR_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  poci_readout dut (
    .sclk      (sclk),
    .rstn      (rstn),
    .serial_in (serial_in),
    .reg_rdata (reg_rdata),
    .serial_out(serial_out),
    .reg_raddr (reg_raddr),
    .rd_strobe (rd_strobe),
    .byte_done (byte_done),
    .state_dbg (state_dbg)
  );

  always #5 sclk = ~sclk;

  assign reg_rdata = reg_raddr * 8'd3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] turn_exp(input logic [7:0] a);
    return ECHO ? a : 8'hA5;
  endfunction

  // Outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge sclk);
    #1;
    if (byte_done) done_pulses++;
    if (rd_strobe) strobe_pulses++;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
  endtask

  task automatic send_addr(input logic [7:0] a);
    for (int i = 7; i >= 0; i--) begin
      serial_in = a[i];
      tick();
    end
    serial_in = 1'b0;
  endtask

  // serial_in is randomised: it must be ignored outside the address byte.
  task automatic read_byte(output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      b[i]      = serial_out;
      serial_in = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  logic [7:0] b;

  initial begin
    rstn      = 1'b0;
    serial_in = 1'b0;
    #2;
    check("rst serial_out", serial_out, 0);
    check("rst raddr", reg_raddr, 0);
    check("rst strobe", rd_strobe, 0);
    check("rst byte_done", byte_done, 0);
    check("rst state", state_dbg, 0);
    #1;
    rstn = 1'b1;

    // Test 1/2: address 0x05, turnaround then two data bytes
    done_pulses = 0; strobe_pulses = 0;
    send_addr(8'h05);
    check("t1 raddr", reg_raddr, 8'h05);
    check("t1 strobe", rd_strobe, 1);
    check("t1 byte_done", byte_done, 1);
    check("t1 first bit", serial_out, ECHO ? 0 : 1);
    strobe_pulses = 0;
    read_byte(b);
    check("t1 turn byte", b, turn_exp(8'h05));
    check("t1 strobe count", strobe_pulses, 1);
    check("t2 raddr6", reg_raddr, 8'h06);
    read_byte(b);
    check("t2 data0", b, 8'h0F);
    check("t2 raddr7", reg_raddr, 8'h07);
    read_byte(b);
    check("t2 data1", b, 8'h12);
    check("t2 raddr8", reg_raddr, 8'h08);

    // Test 3: address wrap
    do_reset();
    send_addr(8'hFF);
    check("t3 raddr ff", reg_raddr, 8'hFF);
    read_byte(b);
    check("t3 turn byte", b, turn_exp(8'hFF));
    check("t3 raddr 00", reg_raddr, 8'h00);
    read_byte(b);
    check("t3 data ff", b, 8'hFD);
    check("t3 raddr 01", reg_raddr, 8'h01);
    read_byte(b);
    check("t3 data 00", b, 8'h00);

    // Test 4: async reset mid data byte
    do_reset();
    send_addr(8'h2A);
    read_byte(b);
    for (int i = 0; i < 4; i++) tick();
    check("t4 pre serial_out", serial_out, 1);
    check("t4 pre raddr", reg_raddr, 8'h2B);
    #2;
    rstn = 1'b0;
    #1;
    check("t4 serial_out", serial_out, 0);
    check("t4 raddr", reg_raddr, 0);
    check("t4 strobe", rd_strobe, 0);
    check("t4 byte_done", byte_done, 0);
    check("t4 state", state_dbg, 0);
    rstn = 1'b1;
    send_addr(8'h10);
    check("t4 raddr 10", reg_raddr, 8'h10);
    read_byte(b);
    check("t4 turn byte", b, turn_exp(8'h10));
    read_byte(b);
    check("t4 data", b, 8'h30);

    // Test 5: turnaround depends on echo option; data unchanged
    do_reset();
    send_addr(8'h3C);
    read_byte(b);
    check("t5 turn byte", b, turn_exp(8'h3C));
    check("t5 state", state_dbg, 2);
    read_byte(b);
    check("t5 data", b, 8'hB4);

    // Test 6: random serial_in over 4 data bytes
    do_reset();
    send_addr(8'h40);
    read_byte(b);
    check("t6 raddr start", reg_raddr, 8'h41);
    done_pulses = 0;
    read_byte(b);
    check("t6 data0", b, 8'hC0);
    check("t6 raddr0", reg_raddr, 8'h42);
    read_byte(b);
    check("t6 data1", b, 8'hC3);
    check("t6 raddr1", reg_raddr, 8'h43);
    read_byte(b);
    check("t6 data2", b, 8'hC6);
    check("t6 raddr2", reg_raddr, 8'h44);
    read_byte(b);
    check("t6 data3", b, 8'hC9);
    check("t6 raddr3", reg_raddr, 8'h45);
    check("t6 done pulses", done_pulses, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
